// File: rtl/lsu_ctrl_if.sv
// Single-port data bus between the load/store sequencer and data memory.
interface lsu_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );
    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/lsu_ctrl.sv
// MEM-stage load/store sequencer: one access at a time onto a single-port bus,
// with stall, lane handling, access faults and a bus timeout.
module lsu_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic              ex_is_load,
    input  logic              ex_is_store,
    input  logic [2:0]        ex_funct3,
    input  logic [31:0]       ex_addr,
    input  logic [31:0]       ex_wdata,
    input  logic [4:0]        ex_rd,
    output logic              stall,
    lsu_ctrl_if.master        bus,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [2:0]        wb_funct3,
    output logic [31:0]       wb_ldata,
    output logic              lsu_exc,
    output logic [1:0]        exc_cause,
    output logic [31:0]       exc_addr
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t           state, state_nx;
    logic [31:0]      addr_q, wdata_q;
    logic [2:0]       f3_q;
    logic [4:0]       rd_q;
    logic [3:0]       wstrb_q;
    logic             we_q, tmo_q;
    logic [CNT_W-1:0] cnt;

    logic             access, illegal, misal, go, tmo_hit;
    logic [3:0]       strb_nx;
    logic [31:0]      wdata_nx;

    // rst gates the IDLE decode so stall and faults drop as soon as reset rises
    assign access  = ex_valid && (ex_is_load || ex_is_store) && !rst;
    assign illegal = (ex_is_load && ex_is_store)
                  || (ex_is_load && (ex_funct3 == 3'b011 || ex_funct3 == 3'b110 || ex_funct3 == 3'b111))
                  || (ex_is_store && !(ex_funct3 == 3'b000 || ex_funct3 == 3'b001 || ex_funct3 == 3'b010));
    assign misal   = (ex_funct3[1:0] == 2'b01 && ex_addr[0])
                  || (ex_funct3[1:0] == 2'b10 && ex_addr[1:0] != 2'b00);
    assign go      = access && !illegal && !misal;
    assign tmo_hit = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));

    always_comb begin
        wdata_nx = ex_wdata;
        strb_nx  = 4'b1111;
        case (ex_funct3[1:0])
            2'b00:   begin wdata_nx = {4{ex_wdata[7:0]}};  strb_nx = 4'b0001 << ex_addr[1:0]; end
            2'b01:   begin wdata_nx = {2{ex_wdata[15:0]}}; strb_nx = 4'b0011 << ex_addr[1:0]; end
            default: ;
        endcase
        if (!ex_is_store) strb_nx = 4'b0000;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx      = state;
        stall         = 1'b0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wstrb = '0;
        bus.mem_wdata = '0;
        wb_valid      = 1'b0;
        lsu_exc       = 1'b0;
        exc_cause     = 2'b00;
        exc_addr      = '0;
        case (state)
            IDLE: if (access) begin
                if (illegal || misal) begin
                    lsu_exc   = 1'b1;
                    exc_cause = illegal ? 2'b10 : 2'b01;
                    exc_addr  = ex_addr;
                end else begin
                    stall    = 1'b1;
                    state_nx = REQ;
                end
            end
            REQ: begin
                stall         = 1'b1;
                bus.mem_req   = 1'b1;
                bus.mem_we    = we_q;
                bus.mem_addr  = {addr_q[31:2], 2'b00};
                bus.mem_wstrb = wstrb_q;
                bus.mem_wdata = wdata_q;
                if (bus.mem_gnt) state_nx = we_q ? DONE : WAIT;
                else if (tmo_hit) state_nx = DONE;
            end
            WAIT: begin
                stall = 1'b1;
                if (bus.mem_rvalid || tmo_hit) state_nx = DONE;
            end
            DONE: begin
                state_nx = IDLE;
                wb_valid = !we_q && !tmo_q;
                if (tmo_q) begin
                    lsu_exc   = 1'b1;
                    exc_cause = 2'b11;
                    exc_addr  = addr_q;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            f3_q      <= '0;
            rd_q      <= '0;
            wstrb_q   <= '0;
            we_q      <= 1'b0;
            tmo_q     <= 1'b0;
            cnt       <= '0;
            wb_rd     <= '0;
            wb_funct3 <= '0;
            wb_ldata  <= '0;
        end else begin
            case (state)
                IDLE: if (go) begin
                    addr_q  <= ex_addr;
                    wdata_q <= wdata_nx;
                    f3_q    <= ex_funct3;
                    rd_q    <= ex_rd;
                    wstrb_q <= strb_nx;
                    we_q    <= ex_is_store;
                    tmo_q   <= 1'b0;
                    cnt     <= '0;
                end
                REQ: begin
                    if (bus.mem_gnt)  cnt   <= '0;
                    else if (tmo_hit) tmo_q <= 1'b1;
                    else              cnt   <= cnt + 1'b1;
                end
                WAIT: begin
                    if (bus.mem_rvalid) begin
                        wb_ldata  <= bus.mem_rdata >> {addr_q[1:0], 3'b000};
                        wb_rd     <= rd_q;
                        wb_funct3 <= f3_q;
                    end else if (tmo_hit) tmo_q <= 1'b1;
                    else                  cnt   <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed scenarios plus randomized accesses against a
// byte-lane reference model.
module tb_lsu_ctrl;
    localparam int TMO = 4;

    logic        clk = 1'b0, rst = 1'b1;
    logic        ex_valid = 1'b0, ex_is_load = 1'b0, ex_is_store = 1'b0;
    logic [2:0]  ex_funct3 = '0;
    logic [31:0] ex_addr = '0, ex_wdata = '0;
    logic [4:0]  ex_rd = '0;
    logic        stall, wb_valid, lsu_exc;
    logic [4:0]  wb_rd;
    logic [2:0]  wb_funct3;
    logic [31:0] wb_ldata, exc_addr;
    logic [1:0]  exc_cause;

    int n_vec = 0, n_err = 0;

    lsu_ctrl_if bus();

    lsu_ctrl #(.TIMEOUT(TMO), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
        .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
        .stall(stall), .bus(bus.master),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_funct3(wb_funct3), .wb_ldata(wb_ldata),
        .lsu_exc(lsu_exc), .exc_cause(exc_cause), .exc_addr(exc_addr)
    );

    always #5 clk = ~clk;

    // observations of the last access
    int          o_cyc, o_stall, o_nreq, o_wbv, o_wbcyc, o_exc;
    bit          o_unstable, o_done;
    logic [31:0] o_maddr, o_mwdata, o_ldata, o_eaddr;
    logic [3:0]  o_strb;
    logic        o_we;
    logic [1:0]  o_cause;
    logic [4:0]  o_wbrd;
    logic [2:0]  o_wbf3;

    // reference: byte-lane view of an RV32I access
    function automatic void model(input logic ld, st, input logic [2:0] f3,
                                  input logic [31:0] a, d, rdat,
                                  output logic [1:0] cause, output logic [3:0] strb,
                                  output logic [31:0] wd, ldv);
        int sz, o;
        sz = 1 << f3[1:0];
        o  = int'(a[1:0]);
        cause = 2'd0;
        if ((ld && st) || (ld && (f3 == 3 || f3 == 6 || f3 == 7)) || (st && f3 > 2)) cause = 2'd2;
        else if (a % sz != 0) cause = 2'd1;
        strb = '0;
        wd   = '0;
        if (sz <= 4)
            for (int i = 0; i < 4; i++) begin
                wd[8*i +: 8] = d[8*(i % sz) +: 8];
                if (st && i >= o && i < o + sz) strb[i] = 1'b1;
            end
        ldv = rdat >> (8 * o);
    endfunction

    // drives one access and records what the DUT does until stall releases
    task automatic do_access(input logic ld, st, input logic [2:0] f3, input logic [31:0] a, d,
                             input logic [4:0] rd, input int gdly, rdly,
                             input logic [31:0] rdat, input bit early);
        int wcnt;
        bit granted;
        wcnt = 0; granted = 0;
        o_cyc = 0; o_stall = 0; o_nreq = 0; o_wbv = 0; o_wbcyc = -1; o_exc = 0;
        o_unstable = 0; o_done = 0; o_maddr = '0; o_mwdata = '0; o_ldata = '0; o_eaddr = '0;
        o_strb = '0; o_we = 1'b0; o_cause = '0; o_wbrd = '0; o_wbf3 = '0;
        ex_valid = 1'b1; ex_is_load = ld; ex_is_store = st; ex_funct3 = f3;
        ex_addr = a; ex_wdata = d; ex_rd = rd;
        for (int c = 0; c < 40 && !o_done; c++) begin
            @(negedge clk);
            o_cyc = c + 1;
            bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = $urandom;
            if (stall) o_stall++;
            if (wb_valid) begin
                o_wbv++; o_wbcyc = c; o_ldata = wb_ldata; o_wbrd = wb_rd; o_wbf3 = wb_funct3;
            end
            if (lsu_exc) begin o_exc++; o_cause = exc_cause; o_eaddr = exc_addr; end
            if (bus.mem_req) begin
                if (o_nreq == 0) begin
                    o_maddr = bus.mem_addr; o_mwdata = bus.mem_wdata;
                    o_strb = bus.mem_wstrb; o_we = bus.mem_we;
                end else if ({bus.mem_addr, bus.mem_wdata, bus.mem_wstrb, bus.mem_we}
                             !== {o_maddr, o_mwdata, o_strb, o_we}) o_unstable = 1;
                if (o_nreq == gdly) begin bus.mem_gnt = 1'b1; granted = !bus.mem_we; end
                else if (early) bus.mem_rvalid = 1'b1;
                o_nreq++;
            end else if (granted) begin
                if (wcnt == rdly) begin bus.mem_rvalid = 1'b1; bus.mem_rdata = rdat; end
                wcnt++;
            end
            if (!stall) o_done = 1;
        end
        @(posedge clk); #1;
        ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
        n_vec++;
        if (!o_done) begin n_err++; $display("FAIL access_bound: stall still %b after %0d cycles, want 0", stall, o_cyc); end
    endtask

    task automatic test_reset;
        #2;
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL rst_stall: got %b want 0", stall); end
        n_vec++; if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b want 0", bus.mem_req); end
        n_vec++; if ({wb_valid, lsu_exc} !== 2'b00) begin n_err++; $display("FAIL rst_pulses: got %b want 00", {wb_valid, lsu_exc}); end
        n_vec++; if ({bus.mem_addr, exc_cause, wb_ldata, wb_rd} !== '0) begin n_err++; $display("FAIL rst_data: got %h want 0", {bus.mem_addr, exc_cause, wb_ldata, wb_rd}); end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_lbu;
        do_access(1, 0, 3'b100, 32'h1003, 32'h0, 5'd7, 0, 0, 32'hA1B2C3D4, 0);
        n_vec++; if (o_maddr !== 32'h1000) begin n_err++; $display("FAIL lbu_addr: got %h want 00001000", o_maddr); end
        n_vec++; if ({o_stall, o_cyc} !== {32'd3, 32'd4}) begin n_err++; $display("FAIL lbu_stall: got %0d high of %0d want 3 of 4", o_stall, o_cyc); end
        n_vec++; if ({o_wbv, o_wbcyc} !== {32'd1, 32'd3}) begin n_err++; $display("FAIL lbu_wbv: got %0d at cyc %0d want 1 at 3", o_wbv, o_wbcyc); end
        n_vec++; if ({o_ldata, o_wbf3, o_wbrd} !== {32'h000000A1, 3'b100, 5'd7}) begin n_err++; $display("FAIL lbu_wb: got %h/%b/%0d want 000000a1/100/7", o_ldata, o_wbf3, o_wbrd); end
        n_vec++; if ({o_strb, o_we} !== 5'b0) begin n_err++; $display("FAIL lbu_strb: got %b/%b want 0000/0", o_strb, o_we); end
    endtask

    task automatic test_sh;
        do_access(0, 1, 3'b001, 32'h2002, 32'h0000BEEF, 5'd0, 0, 0, 32'h0, 0);
        n_vec++; if ({o_mwdata, o_strb, o_we} !== {32'hBEEFBEEF, 4'b1100, 1'b1}) begin n_err++; $display("FAIL sh_bus: got %h/%b/%b want beefbeef/1100/1", o_mwdata, o_strb, o_we); end
        n_vec++; if ({o_stall, o_cyc, o_wbv} !== {32'd2, 32'd3, 32'd0}) begin n_err++; $display("FAIL sh_timing: got stall %0d cyc %0d wbv %0d want 2 3 0", o_stall, o_cyc, o_wbv); end
    endtask

    task automatic test_faults;
        do_access(1, 0, 3'b010, 32'h3001, 32'h0, 5'd1, 0, 0, 32'h0, 0);
        n_vec++; if ({o_exc, o_cause, o_eaddr} !== {32'd1, 2'b01, 32'h3001}) begin n_err++; $display("FAIL misal: got %0d/%b/%h want 1/01/00003001", o_exc, o_cause, o_eaddr); end
        n_vec++; if ({o_nreq, o_stall} !== {32'd0, 32'd0}) begin n_err++; $display("FAIL misal_bus: got req %0d stall %0d want 0 0", o_nreq, o_stall); end
        do_access(1, 0, 3'b011, 32'h0100, 32'h0, 5'd1, 0, 0, 32'h0, 0);
        n_vec++; if ({o_exc, o_cause, o_nreq} !== {32'd1, 2'b10, 32'd0}) begin n_err++; $display("FAIL ill_ld: got %0d/%b/%0d want 1/10/0", o_exc, o_cause, o_nreq); end
        do_access(1, 1, 3'b010, 32'h0201, 32'h0, 5'd1, 0, 0, 32'h0, 0);
        n_vec++; if ({o_exc, o_cause} !== {32'd1, 2'b10}) begin n_err++; $display("FAIL ill_both: got %0d/%b want 1/10", o_exc, o_cause); end
        do_access(0, 1, 3'b100, 32'h0300, 32'h0, 5'd1, 0, 0, 32'h0, 0);
        n_vec++; if ({o_exc, o_cause, o_stall} !== {32'd1, 2'b10, 32'd0}) begin n_err++; $display("FAIL ill_st: got %0d/%b/%0d want 1/10/0", o_exc, o_cause, o_stall); end
    endtask

    task automatic test_gnt_hold;
        do_access(1, 0, 3'b010, 32'h4000, 32'h0, 5'd9, 3, 0, 32'h12345678, 1);
        n_vec++; if ({o_nreq, o_unstable} !== {32'd4, 1'b0}) begin n_err++; $display("FAIL hold_req: got %0d cycles unstable=%b want 4 0", o_nreq, o_unstable); end
        n_vec++; if ({o_wbv, o_ldata, o_stall} !== {32'd1, 32'h12345678, 32'd6}) begin n_err++; $display("FAIL hold_wb: got %0d/%h/%0d want 1/12345678/6", o_wbv, o_ldata, o_stall); end
    endtask

    task automatic test_timeout;
        do_access(1, 0, 3'b010, 32'h5004, 32'h0, 5'd2, 0, -1, 32'h0, 0);
        n_vec++; if ({o_exc, o_cause, o_eaddr, o_wbv} !== {32'd1, 2'b11, 32'h5004, 32'd0}) begin n_err++; $display("FAIL tmo_wait: got %0d/%b/%h/%0d want 1/11/00005004/0", o_exc, o_cause, o_eaddr, o_wbv); end
        n_vec++; if (o_stall !== 6) begin n_err++; $display("FAIL tmo_wait_len: got stall %0d want 6", o_stall); end
        do_access(0, 1, 3'b000, 32'h6001, 32'h55, 5'd0, 100, 0, 32'h0, 0);
        n_vec++; if ({o_exc, o_cause, o_nreq, o_stall} !== {32'd1, 2'b11, 32'd4, 32'd5}) begin n_err++; $display("FAIL tmo_req: got %0d/%b req %0d stall %0d want 1/11/4/5", o_exc, o_cause, o_nreq, o_stall); end
        do_access(1, 0, 3'b101, 32'h7002, 32'h0, 5'd4, 0, 1, 32'h89ABCDEF, 0);
        n_vec++; if ({o_exc, o_wbv, o_ldata, o_stall} !== {32'd0, 32'd1, 32'h000089AB, 32'd4}) begin n_err++; $display("FAIL tmo_next: got %0d/%0d/%h/%0d want 0/1/000089ab/4", o_exc, o_wbv, o_ldata, o_stall); end
    endtask

    task automatic test_reset_mid;
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_is_store = 1'b0; ex_funct3 = 3'b010;
        ex_addr = 32'h500; ex_rd = 5'd3;
        @(negedge clk);
        @(negedge clk);
        n_vec++; if (bus.mem_req !== 1'b1) begin n_err++; $display("FAIL rmid_req: got %b want 1", bus.mem_req); end
        bus.mem_gnt = 1'b1;
        @(posedge clk); #1; bus.mem_gnt = 1'b0;
        rst = 1'b1; #1;
        n_vec++; if ({stall, bus.mem_req} !== 2'b00) begin n_err++; $display("FAIL rmid_async: got stall/req %b want 00", {stall, bus.mem_req}); end
        @(negedge clk); rst = 1'b0; ex_valid = 1'b0; ex_is_load = 1'b0;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); bus.mem_rvalid = 1'b0;
            n_vec++; if ({wb_valid, stall, lsu_exc} !== 3'b000) begin n_err++; $display("FAIL rmid_idle: got wbv/stall/exc %b want 000", {wb_valid, stall, lsu_exc}); end
        end
        @(posedge clk); #1;
        do_access(1, 0, 3'b010, 32'h600, 32'h0, 5'd5, 0, 0, 32'hCAFEF00D, 0);
        n_vec++; if ({o_stall, o_wbv, o_ldata} !== {32'd3, 32'd1, 32'hCAFEF00D}) begin n_err++; $display("FAIL rmid_next: got %0d/%0d/%h want 3/1/cafef00d", o_stall, o_wbv, o_ldata); end
    endtask

    task automatic test_random;
        logic        ld, st;
        logic [2:0]  f3;
        logic [31:0] a, d, rdat, wd, ldv;
        logic [4:0]  rd;
        logic [1:0]  cause;
        logic [3:0]  strb;
        int          kind, gdly, rdly, exp_stall;
        for (int it = 0; it < 150; it++) begin
            kind = $urandom_range(0, 19);
            ld = (kind < 10); st = (kind == 0) || (kind >= 10);
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) f3 = ld ? 3'($urandom_range(0, 5) == 3 ? 2 : $urandom_range(0, 5)) : 3'($urandom_range(0, 2));
            a = $urandom; d = $urandom; rdat = $urandom; rd = 5'($urandom);
            gdly = $urandom_range(0, 3); rdly = $urandom_range(0, 3);
            model(ld, st, f3, a, d, rdat, cause, strb, wd, ldv);
            do_access(ld, st, f3, a, d, rd, gdly, rdly, rdat, bit'($urandom_range(0, 1)));
            if (cause != 0) begin
                n_vec++; if ({o_exc, o_cause, o_eaddr, o_nreq, o_stall} !== {32'd1, cause, a, 32'd0, 32'd0}) begin n_err++; $display("FAIL rnd_fault: it %0d got %0d/%b/%h/%0d/%0d want 1/%b/%h/0/0", it, o_exc, o_cause, o_eaddr, o_nreq, o_stall, cause, a); end
            end else begin
                exp_stall = 2 + gdly + (ld ? rdly + 1 : 0);
                n_vec++; if ({o_stall, o_exc} !== {exp_stall, 32'd0}) begin n_err++; $display("FAIL rnd_stall: it %0d got %0d exc %0d want %0d 0", it, o_stall, o_exc, exp_stall); end
                n_vec++; if ({o_maddr, o_strb, o_we, o_unstable} !== {a & 32'hFFFF_FFFC, strb, st, 1'b0}) begin n_err++; $display("FAIL rnd_bus: it %0d got %h/%b/%b/%b want %h/%b/%b/0", it, o_maddr, o_strb, o_we, o_unstable, a & 32'hFFFF_FFFC, strb, st); end
                if (st) begin
                    n_vec++; if ({o_mwdata, o_wbv} !== {wd, 32'd0}) begin n_err++; $display("FAIL rnd_st: it %0d got %h wbv %0d want %h 0", it, o_mwdata, o_wbv, wd); end
                end else begin
                    n_vec++; if ({o_wbv, o_ldata, o_wbrd, o_wbf3} !== {32'd1, ldv, rd, f3}) begin n_err++; $display("FAIL rnd_ld: it %0d got %0d/%h/%0d/%b want 1/%h/%0d/%b", it, o_wbv, o_ldata, o_wbrd, o_wbf3, ldv, rd, f3); end
                end
            end
        end
    endtask

    initial begin
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
        test_reset;
        test_lbu;
        test_sh;
        test_faults;
        test_gnt_hold;
        test_timeout;
        test_reset_mid;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store sequencer in the MEM stage of the 5-stage RV32I pipeline.
- Accepts one access at a time and handshakes it onto the single-port data bus.
- Produces word-aligned address, byte strobes and lane-replicated store data.
- Returns lane-shifted raw load data, with funct3 and rd, to the WB-stage load sign/zero-extension filter; holds the pipeline via stall and reports access exceptions.

Parameters:
- TIMEOUT, 255, bus cycles allowed in REQ or WAIT before abort; 0 disables the timeout.
- CNT_W, 8, width of the timeout counter; TIMEOUT must be less than 2^CNT_W.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ex_valid  in  1  MEM-stage instruction valid
- ex_is_load  in  1  instruction is a load
- ex_is_store  in  1  instruction is a store
- ex_funct3  in  3  RV32I load/store funct3
- ex_addr  in  32  effective byte address
- ex_wdata  in  32  store data (rs2)
- ex_rd  in  5  load destination register
- stall  out  1  freeze IF..MEM pipeline registers
- mem_req  out  1  bus request
- mem_we  out  1  1 = write
- mem_addr  out  32  word address {addr[31:2],2'b00}
- mem_wstrb  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read word
- wb_valid  out  1  load result valid (one-cycle pulse)
- wb_rd  out  5  load destination
- wb_funct3  out  3  funct3 passed to the WB filter
- wb_ldata  out  32  mem_rdata >> (8*addr[1:0])
- lsu_exc  out  1  exception pulse
- exc_cause  out  2  01 misaligned, 10 illegal, 11 bus timeout
- exc_addr  out  32  faulting byte address

Behaviour:
- Reset (async): state IDLE, counter 0. All outputs 0, including stall, mem_req, wb_valid and lsu_exc.
- Validity check in IDLE, combinational:
  - Illegal: ex_is_load and ex_is_store both high; load funct3 in {011,110,111}; store funct3 not in {000,001,010}.
  - Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - On either fault: lsu_exc=1, exc_cause set (illegal takes priority), exc_addr=ex_addr, stall=0, no bus access, state stays IDLE.
- States:
  - IDLE: a valid legal access sets stall=1 combinationally. At the clock edge it captures addr, funct3, rd, we, replicated wdata and wstrb, clears the counter, and moves to REQ. With no access: stall=0 and the block stays in IDLE.
  - REQ: mem_req=1 with captured fields; stall=1. On mem_gnt, a store goes to DONE and a load goes to WAIT (counter cleared). mem_rvalid is ignored here; the bus never returns data in the grant cycle.
  - WAIT: mem_req=0, stall=1. On mem_rvalid, register wb_ldata and go to DONE. mem_gnt is ignored.
  - DONE: stall=0 for exactly one cycle so the pipeline advances. Inputs are ignored (they still show the completed instruction). A load asserts wb_valid=1 with wb_rd, wb_funct3 and wb_ldata held. Next state is IDLE.
- Timeout: the counter increments each cycle in REQ/WAIT. When it reaches TIMEOUT without gnt/rvalid: lsu_exc=1 (registered, shown in DONE), cause=11, exc_addr=captured addr, mem_req drops, state goes to DONE, wb_valid=0.
- Latency: a load with gnt in the first REQ cycle and rvalid one cycle later takes 4 cycles IDLE->REQ->WAIT->DONE, with stall high for 3. A store takes 3 cycles, with stall high for 2.
- Store lanes, with o = addr[1:0]:
  - SB: wdata={4{d[7:0]}}, wstrb=0001<<o.
  - SH: wdata={2{d[15:0]}}, wstrb=0011<<o.
  - SW: wdata=d, wstrb=1111.
- Loads drive mem_wstrb=0000 and mem_we=0.
- mem_req, mem_addr, mem_we, mem_wstrb and mem_wdata stay stable while mem_req=1 and no gnt has been received.
- wb_ldata, wb_rd and wb_funct3 keep their last values outside DONE; only wb_valid qualifies them.
- Reset mid-transaction aborts immediately: mem_req and stall drop asynchronously and any later rvalid is ignored.

Test Plan:
- LBU at 0x1003, gnt in cycle 1, rvalid in cycle 2 with rdata 0xA1B2C3D4 -> mem_addr 0x1000, wb_valid in cycle 3, wb_ldata 0x000000A1, wb_funct3 100, stall 1,1,1,0.
- SH at 0x2002 with rs2 0x0000BEEF -> mem_wdata 0xBEEFBEEF, mem_wstrb 1100, mem_we 1, no wb_valid, stall released 1 cycle after gnt.
- LW at 0x3001 -> lsu_exc=1, cause 01, exc_addr 0x3001, mem_req never asserted, stall 0. Load with funct3 011 -> cause 10.
- LW with mem_gnt held low for 3 cycles -> mem_req and mem_addr stable for 4 cycles, then normal completion; rvalid arriving during REQ is ignored.
- TIMEOUT=4, load with rvalid never returned -> lsu_exc in DONE with cause 11, wb_valid 0, state back to IDLE; the next access proceeds normally.
- Assert rst while in WAIT, then deliver rvalid -> mem_req/stall 0 immediately, no wb_valid, state IDLE.
